// File: rtl/uart_rx_core_if.sv
// Serial line, frame configuration and received-word outputs of the UART receiver.
interface uart_rx_core_if #(parameter int DATA_WIDTH = 8);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: majority-voted bits, optional parity, one stop bit,
// registered one-cycle result pulses the cycle after the stop bit ends.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_core_if.slave rx
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [5:0]            presc_q, presc_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            smp_q, smp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  perr_q, perr_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [5:0] mid;
    logic       last_edge;
    logic       vote;

    assign mid       = {1'b0, presc_q[5:1]};
    assign last_edge = (edge_q == presc_q - 6'd1);
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            presc_q   <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            data_q    <= '0;
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            perr_q    <= 1'b0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            presc_q   <= presc_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            data_q    <= data_d;
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            perr_q    <= perr_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        presc_d   = presc_q;
        bit_d     = bit_q;
        smp_d     = smp_q;
        data_d    = data_q;
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        perr_d    = perr_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        // The 6-bit edge counter always wraps, so an illegal Prescale cannot stall the FSM.
        if (state_q != IDLE) begin
            edge_d = last_edge ? 6'd0 : edge_q + 6'd1;
            if (edge_q == mid - 6'd1) smp_d[0] = rx.RX_IN;
            if (edge_q == mid)        smp_d[1] = rx.RX_IN;
            if (edge_q == mid + 6'd1) smp_d[2] = rx.RX_IN;
        end

        case (state_q)
            IDLE: begin
                if (!rx.RX_IN) begin
                    // The detection cycle is edge 0 of the start bit.
                    state_d   = START;
                    edge_d    = 6'd1;
                    bit_d     = '0;
                    perr_d    = 1'b0;
                    presc_d   = rx.Prescale;
                    par_en_d  = rx.PAR_EN;
                    par_typ_d = rx.PAR_TYP;
                end
            end
            START: begin
                if (last_edge) begin
                    state_d = vote ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last_edge) begin
                    data_d[bit_q] = vote;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    if (vote != ((^data_q) ^ par_typ_q)) perr_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_d = IDLE;
                    if (!perr_q && vote) begin
                        dv_d    = 1'b1;
                        pdata_d = data_q;
                    end else begin
                        pe_d = perr_q;
                        se_d = !vote;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.P_DATA     = pdata_q;
    assign rx.data_valid = dv_q;
    assign rx.par_err    = pe_q;
    assign rx.stp_err    = se_q;
    assign rx.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames against a frame-level outcome model of the UART receiver.
module tb_uart_rx_core;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_rx_core_if #(.DATA_WIDTH(8)) rx();
    uart_rx_core #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .rx(rx));

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] exp_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK)
        if (rx.data_valid || rx.par_err || rx.stp_err)
            evq.push_back('{cyc, rx.data_valid, rx.par_err, rx.stp_err, rx.P_DATA});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_presc();
        int ps[3] = '{8, 16, 32};
        return ps[$urandom_range(2)];
    endfunction

    task automatic hold(input logic b, input int p);
        rx.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit, input int p, input bit scramble);
        rx.PAR_EN   = pen;
        rx.PAR_TYP  = ptyp;
        rx.Prescale = 6'(p);
        hold(1'b0, p);
        // Configuration is latched at start detection; disturbing it afterwards must not matter.
        if (scramble) begin
            rx.PAR_EN   = 1'($urandom);
            rx.PAR_TYP  = 1'($urandom);
            rx.Prescale = 6'(pick_presc());
        end
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pen) hold(pbit, p);
        hold(sbit, p);
        rx.RX_IN = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                               input logic ptyp, input logic pbit, input logic sbit,
                               input int p, input bit scramble);
        logic exp_pe, exp_se, exp_dv;
        evq.delete();
        send_frame(d, pen, ptyp, pbit, sbit, p, scramble);
        repeat (3) @(negedge CLK);
        exp_pe = pen && (pbit != ((^d) ^ ptyp));
        exp_se = !sbit;
        exp_dv = !exp_pe && !exp_se;
        if (exp_dv) exp_pdata = d;
        chk({tag, "_events"}, evq.size(), 1);
        if (evq.size() >= 1) begin
            chk({tag, "_dv"}, evq[0].dv, exp_dv);
            chk({tag, "_pe"}, evq[0].pe, exp_pe);
            chk({tag, "_se"}, evq[0].se, exp_se);
        end
        chk({tag, "_pdata"}, rx.P_DATA, exp_pdata);
        chk({tag, "_busy"}, rx.busy, 0);
    endtask

    initial begin
        int         n;
        logic [7:0] d;
        logic       pen, ptyp, pbit, sbit;
        int         p;

        RST         = 1'b1;
        rx.RX_IN    = 1'b1;
        rx.PAR_EN   = 1'b0;
        rx.PAR_TYP  = 1'b0;
        rx.Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", rx.P_DATA, 0);
        chk("rst_busy", rx.busy, 0);
        chk("rst_dv", rx.data_valid, 0);
        chk("rst_pe", rx.par_err, 0);
        chk("rst_se", rx.stp_err, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        check_frame("p8_even_a5", 8'hA5, 1, 0, 0, 1, 8, 0);
        check_frame("p16_odd_bad_3c", 8'h3C, 1, 1, 0, 1, 16, 0);
        check_frame("p32_stop0_81", 8'h81, 0, 0, 0, 0, 32, 0);

        // Start-bit glitch: low for three cycles only.
        evq.delete();
        rx.Prescale = 6'd16;
        hold(1'b0, 3);
        rx.RX_IN = 1'b1;
        chk("glitch_busy_hi", rx.busy, 1);
        n = 0;
        while (rx.busy && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("glitch_busy_fall", n, 13);
        repeat (3) @(negedge CLK);
        chk("glitch_events", evq.size(), 0);
        chk("glitch_pdata", rx.P_DATA, exp_pdata);

        // Back-to-back frames at Prescale 8, no parity: 10 bits x 8 cycles apart.
        evq.delete();
        send_frame(8'h12, 0, 0, 0, 1, 8, 0);
        send_frame(8'h34, 0, 0, 0, 1, 8, 0);
        repeat (3) @(negedge CLK);
        chk("b2b_events", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("b2b_gap", evq[1].cyc - evq[0].cyc, 80);
            chk("b2b_d0", evq[0].d, 8'h12);
            chk("b2b_d1", evq[1].d, 8'h34);
            chk("b2b_dv", {evq[0].dv, evq[1].dv}, 2'b11);
        end
        exp_pdata = 8'h34;
        chk("b2b_pdata", rx.P_DATA, exp_pdata);

        // Reset in the middle of the data bits.
        evq.delete();
        rx.Prescale = 6'd8;
        rx.PAR_EN   = 1'b0;
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b1, 8);
        hold(1'b0, 4);
        RST      = 1'b1;
        rx.RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("midrst_busy", rx.busy, 0);
        chk("midrst_pdata", rx.P_DATA, 0);
        chk("midrst_dv", rx.data_valid, 0);
        RST = 1'b0;
        exp_pdata = 8'h00;
        repeat (40) @(negedge CLK);
        chk("midrst_events", evq.size(), 0);
        check_frame("after_rst_5a", 8'h5A, 0, 0, 0, 1, 8, 0);

        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            p    = pick_presc();
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            pbit = (^d) ^ ptyp;
            if ($urandom_range(3) == 0) pbit = ~pbit;
            sbit = ($urandom_range(4) != 0);
            check_frame($sformatf("rand%0d", k), d, pen, ptyp, pbit, sbit, p, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
